// File: rtl/imem_loader_if.sv
// imem_loader_if: instruction handshake in, IMEM write port out
interface imem_loader_if #(parameter int ADDR_W = 10);
   logic              i_valid;
   logic [31:0]       i_instr;
   logic              o_ready;
   logic              o_we;
   logic [ADDR_W-1:0] o_waddr;
   logic [31:0]       o_wdata;
   modport slave  (input i_valid, i_instr, output o_ready, o_we, o_waddr, o_wdata);
   modport master (output i_valid, i_instr, input o_ready, o_we, o_waddr, o_wdata);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: streams instructions into IMEM with optional NOP padding, then releases the core
module imem_loader #(
   parameter int          ADDR_W   = 10,
   parameter int          NOP_PAD  = 3,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_start,
   input  logic            i_finish,
   input  logic            i_pad_en,
   imem_loader_if.slave    bus,
   output logic [ADDR_W:0] o_count,
   output logic            o_full,
   output logic            o_core_run
);
   typedef enum logic [2:0] {IDLE, LOAD, PAD, WRITE, RUN} state_t;
   localparam int PW = NOP_PAD > 1 ? $clog2(NOP_PAD) : 1;
   localparam logic [ADDR_W+1:0] DEPTH = (ADDR_W+2)'(1) << ADDR_W;
   state_t            r_state, w_next;
   logic [31:0]       r_instr, r_wdata;
   logic [ADDR_W-1:0] r_waddr;
   logic [ADDR_W:0]   r_count;
   logic [PW-1:0]     r_pad_cnt;
   logic [ADDR_W+1:0] w_need;
   logic              w_acc, w_we, w_pad_last;
   // A pending i_start suppresses the write so every strobe is counted
   always_comb begin
      w_need      = i_pad_en ? (ADDR_W+2)'(NOP_PAD + 1) : (ADDR_W+2)'(1);
      o_full      = ({1'b0, r_count} + w_need) > DEPTH;
      bus.o_ready = r_state == LOAD && !o_full && !i_start;
      w_acc       = bus.i_valid && bus.o_ready;
      w_we        = (r_state == PAD || r_state == WRITE) && !i_start;
      w_pad_last  = r_pad_cnt == PW'(NOP_PAD - 1);
      bus.o_we    = w_we;
      bus.o_waddr = w_we ? r_count[ADDR_W-1:0] : r_waddr;
      bus.o_wdata = !w_we ? r_wdata : r_state == PAD ? NOP_WORD : r_instr;
      o_count     = r_count;
      o_core_run  = r_state == RUN;
   end
   always_comb begin
      w_next = r_state;
      if (i_start) w_next = LOAD;
      else
         case (r_state)
            LOAD:    w_next = w_acc ? ((i_pad_en && NOP_PAD > 0) ? PAD : WRITE) : i_finish ? RUN : LOAD;
            PAD:     w_next = w_pad_last ? WRITE : PAD;
            WRITE:   w_next = LOAD;
            default: w_next = r_state;
         endcase
   end
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_state   <= IDLE;
         r_instr   <= '0;
         r_wdata   <= '0;
         r_waddr   <= '0;
         r_count   <= '0;
         r_pad_cnt <= '0;
      end else begin
         r_state   <= w_next;
         r_count   <= i_start ? '0 : r_count + (ADDR_W+1)'(w_we);
         r_pad_cnt <= (i_start || w_pad_last || r_state != PAD) ? '0 : r_pad_cnt + PW'(1);
         if (i_start) r_instr <= '0;
         else if (w_acc) r_instr <= bus.i_instr;
         if (w_we) begin
            r_waddr <= bus.o_waddr;
            r_wdata <= bus.o_wdata;
         end
      end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed checks of load, padding, full, run and reset behaviour
module tb_imem_loader;
   logic       clk = 1'b0;
   logic       rst_n, start, finish, pad_en;
   logic [4:0] count;
   logic       full, core_run;
   int         n_checks = 0;
   int         n_fail = 0;
   logic [31:0] words [3] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003};

   imem_loader_if #(.ADDR_W(4)) bus ();

   imem_loader #(.ADDR_W(4), .NOP_PAD(3), .NOP_WORD(32'h0)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_finish(finish), .i_pad_en(pad_en),
      .bus(bus), .o_count(count), .o_full(full), .o_core_run(core_run)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic chk_idle_outs(input string tag);
      chk({tag, "_ready"}, bus.o_ready, 1'b0);
      chk({tag, "_we"}, bus.o_we, 1'b0);
      chk({tag, "_waddr"}, bus.o_waddr, 4'd0);
      chk({tag, "_wdata"}, bus.o_wdata, 32'd0);
      chk({tag, "_count"}, count, 5'd0);
      chk({tag, "_full"}, full, 1'b0);
      chk({tag, "_run"}, core_run, 1'b0);
   endtask

   task automatic start_pulse();
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; finish = 1'b0; pad_en = 1'b0;
      bus.i_valid = 1'b0; bus.i_instr = '0;
      #3;
      chk_idle_outs("rst");
      cyc(); cyc();
      rst_n = 1'b1;
      bus.i_valid = 1'b1;
      cyc(); cyc();
      settle();
      chk_idle_outs("idle");
      bus.i_valid = 1'b0;

      // padded single instruction
      start_pulse();
      pad_en = 1'b1; bus.i_valid = 1'b1; bus.i_instr = 32'h0020_8033;
      settle();
      chk("t1_ready", bus.o_ready, 1'b1);
      chk("t1_full", full, 1'b0);
      cyc();
      bus.i_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("t1_pad_we", bus.o_we, 1'b1);
         chk("t1_pad_addr", bus.o_waddr, 4'(i));
         chk("t1_pad_data", bus.o_wdata, 32'd0);
         chk("t1_pad_ready", bus.o_ready, 1'b0);
         cyc();
      end
      settle();
      chk("t1_wr_we", bus.o_we, 1'b1);
      chk("t1_wr_addr", bus.o_waddr, 4'd3);
      chk("t1_wr_data", bus.o_wdata, 32'h0020_8033);
      chk("t1_wr_ready", bus.o_ready, 1'b0);
      cyc();
      settle();
      chk("t1_ready_back", bus.o_ready, 1'b1);
      chk("t1_we_off", bus.o_we, 1'b0);
      chk("t1_count", count, 5'd4);
      chk("t1_hold_addr", bus.o_waddr, 4'd3);
      chk("t1_hold_data", bus.o_wdata, 32'h0020_8033);

      // unpadded stream with i_valid held
      start_pulse();
      pad_en = 1'b0; bus.i_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         bus.i_instr = words[k];
         settle();
         chk("t2_ready", bus.o_ready, 1'b1);
         chk("t2_idle_we", bus.o_we, 1'b0);
         cyc();
         settle();
         chk("t2_we", bus.o_we, 1'b1);
         chk("t2_addr", bus.o_waddr, 4'(k));
         chk("t2_data", bus.o_wdata, words[k]);
         chk("t2_ready_low", bus.o_ready, 1'b0);
         cyc();
      end
      bus.i_valid = 1'b0;
      settle();
      chk("t2_count", count, 5'd3);

      // fill the memory with four padded instructions
      start_pulse();
      pad_en = 1'b1;
      for (int k = 0; k < 4; k++) begin
         bus.i_valid = 1'b1; bus.i_instr = 32'hA000_0000 + 32'(k);
         settle();
         chk("t3_ready", bus.o_ready, 1'b1);
         chk("t3_count_pre", count, 5'(4 * k));
         cyc();
         bus.i_valid = 1'b0;
         for (int j = 0; j < 4; j++) cyc();
      end
      settle();
      chk("t3_count", count, 5'd16);
      chk("t3_full", full, 1'b1);
      chk("t3_ready_full", bus.o_ready, 1'b0);
      chk("t3_last_data", bus.o_wdata, 32'hA000_0003);
      bus.i_valid = 1'b1; bus.i_instr = 32'hDEAD_BEEF;
      for (int j = 0; j < 10; j++) begin
         settle();
         chk("t3_no_we", bus.o_we, 1'b0);
         cyc();
      end
      pad_en = 1'b0;
      settle();
      chk("t3_full_nopad", full, 1'b1);
      pad_en = 1'b1;
      bus.i_valid = 1'b0;

      // finish then restart
      finish = 1'b1;
      cyc();
      finish = 1'b0;
      settle();
      chk("t4_run", core_run, 1'b1);
      chk("t4_ready", bus.o_ready, 1'b0);
      bus.i_valid = 1'b1;
      for (int j = 0; j < 3; j++) begin
         cyc();
         settle();
         chk("t4_no_we", bus.o_we, 1'b0);
         chk("t4_count_hold", count, 5'd16);
      end
      bus.i_valid = 1'b0;
      start_pulse();
      settle();
      chk("t4_run_off", core_run, 1'b0);
      chk("t4_count0", count, 5'd0);
      chk("t4_ready_on", bus.o_ready, 1'b1);

      // reset during the second pad cycle
      bus.i_valid = 1'b1; bus.i_instr = 32'h5555_AAAA;
      cyc();
      bus.i_valid = 1'b0;
      settle();
      chk("t5_pad1_addr", bus.o_waddr, 4'd0);
      cyc();
      settle();
      chk("t5_pad2_we", bus.o_we, 1'b1);
      chk("t5_pad2_count", count, 5'd1);
      rst_n = 1'b0;
      #1;
      chk_idle_outs("t5_rst");
      cyc(); cyc();
      rst_n = 1'b1;
      for (int j = 0; j < 4; j++) begin
         settle();
         chk("t5_post_we", bus.o_we, 1'b0);
         chk("t5_post_ready", bus.o_ready, 1'b0);
         cyc();
      end
      finish = 1'b1;
      cyc();
      finish = 1'b0;
      settle();
      chk("t5_idle_finish", core_run, 1'b0);

      // i_start during pad aborts the group
      start_pulse();
      bus.i_valid = 1'b1; bus.i_instr = 32'h7777_0007;
      cyc();
      bus.i_valid = 1'b0;
      settle();
      chk("t6_pad1_we", bus.o_we, 1'b1);
      cyc();
      start = 1'b1;
      cyc();
      start = 1'b0;
      settle();
      chk("t6_count0", count, 5'd0);
      chk("t6_ready", bus.o_ready, 1'b1);
      for (int j = 0; j < 4; j++) begin
         settle();
         chk("t6_no_write", bus.o_we, 1'b0);
         cyc();
      end
      chk("t6_count_end", count, 5'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning IMEM word-address width (depth 2**ADDR_W words).
REQ-002 SHALL have parameter NOP_PAD, default 3, meaning NOP words inserted before each padded instruction (0 allowed).
REQ-003 SHALL have parameter NOP_WORD, default 32'h0000_0000, meaning data written for each pad word.
REQ-004 SHALL have port i_clk  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port i_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_start  in  1  pulse: clear write pointer, enter LOAD, halt core.
REQ-007 SHALL have port i_finish  in  1  pulse: end loading, release core.
REQ-008 SHALL have port i_pad_en  in  1  1 = insert NOP_PAD words before each accepted instruction.
REQ-009 SHALL have port i_valid  in  1  instruction word offered.
REQ-010 SHALL have port i_instr  in  32  instruction word.
REQ-011 SHALL have port o_ready  out  1  instruction accepted this cycle when i_valid & o_ready.
REQ-012 SHALL have port o_we  out  1  IMEM write strobe, one word per cycle.
REQ-013 SHALL have port o_waddr  out  ADDR_W  IMEM word address.
REQ-014 SHALL have port o_wdata  out  32  IMEM write data.
REQ-015 SHALL have port o_count  out  ADDR_W+1  words written since last i_start.
REQ-016 SHALL have port o_full  out  1  insufficient space for next instruction group.
REQ-017 SHALL have port o_core_run  out  1  1 = core may execute from IMEM.

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, PAD, WRITE, RUN.
REQ-019 i_start SHALL, from any state, next cycle give LOAD, o_count=0, o_core_run=0, latched instruction discarded, pad counter cleared; i_start has priority over i_finish and handshake.
REQ-020 o_ready SHALL be 1 only in LOAD with o_full=0 and i_start=0.
REQ-021 Need N SHALL equal NOP_PAD+1 when i_pad_en=1 (sampled at accept), else 1; o_full = (o_count + N > 2**ADDR_W), combinational.
REQ-022 On accept in LOAD SHALL latch i_instr; go PAD if padding active and NOP_PAD>0, else WRITE.
REQ-023 PAD SHALL assert o_we with o_wdata=NOP_WORD for exactly NOP_PAD consecutive cycles, then go WRITE.
REQ-024 WRITE SHALL assert o_we for one cycle with latched instruction, then return to LOAD.
REQ-025 Each o_we cycle SHALL use o_waddr=o_count[ADDR_W-1:0] and increment o_count by 1; no wrap, o_full prevents overrun.
REQ-026 Latency: accept at cycle T -> pad writes T+1..T+NOP_PAD, instruction write T+NOP_PAD+1, o_ready may reassert T+NOP_PAD+2 (padding off: write T+1, ready T+2).
REQ-027 i_finish SHALL be honoured only in LOAD (ignored in IDLE, PAD, WRITE, RUN): next cycle RUN, o_core_run=1.
REQ-028 In RUN and IDLE SHALL hold o_ready=0, o_we=0, o_count unchanged; i_valid ignored.
REQ-029 i_valid with o_ready=0 SHALL cause no state change and no write.
REQ-030 o_we=0 SHALL hold o_wdata and o_waddr at last written values (0 after reset).

Reset
REQ-031 i_rst_n=0 SHALL immediately force IDLE, o_ready=0, o_we=0, o_waddr=0, o_wdata=0, o_count=0, o_full=0, o_core_run=0, regardless of state (including mid-PAD).
REQ-032 After reset deassertion SHALL stay IDLE until i_start.

Verification (ADDR_W=4, NOP_PAD=3, NOP_WORD=0)
REQ-033 Bench SHALL check: i_start, pad_en=1, push 32'h00208033 -> writes addr0..2=0, addr3=32'h00208033, o_ready low 4 cycles, o_count=4.
REQ-034 Bench SHALL check: pad_en=0, i_valid held with 3 words -> writes addr0,1,2, one write per accept, o_ready low the cycle after each accept, o_count=3.
REQ-035 Bench SHALL check: four padded instructions -> o_count=16, o_full=1, o_ready=0; fifth i_valid held 10 cycles -> no o_we.
REQ-036 Bench SHALL check: i_finish in LOAD -> o_core_run=1 next cycle, i_valid ignored; then i_start -> o_core_run=0, o_count=0, o_ready=1.
REQ-037 Bench SHALL check: i_rst_n low during second PAD cycle -> all outputs 0 immediately, no further o_we; i_start during PAD (reset high) -> no WRITE, o_count=0 next cycle.
